// File: rtl/fifo_access_arbiter_if.sv
// fifo_access_arbiter_if
//   Bundles the client handshakes (two writers, one reader) and the
//   single-port FIFO control/data lines that the arbiter sits between.
//   master : arbiter side (drives grants, read data, FIFO enables/din, busy)
//   slave  : environment side (clients and FIFO instance)
interface fifo_access_arbiter_if #(
  parameter int WIDTH = 8
);
  // writer 0
  logic             w0_req;
  logic [WIDTH-1:0] w0_data;
  logic             w0_gnt;
  // writer 1
  logic             w1_req;
  logic [WIDTH-1:0] w1_data;
  logic             w1_gnt;
  // reader
  logic             rd_req;
  logic             rd_gnt;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  // FIFO side
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_we_n;
  logic             fifo_oe_n;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  // status
  logic             busy;

  modport master (
    input  w0_req, w0_data, w1_req, w1_data, rd_req,
           fifo_full, fifo_empty, fifo_dout,
    output w0_gnt, w1_gnt, rd_gnt, rd_valid, rd_data,
           fifo_din, fifo_we_n, fifo_oe_n, busy
  );

  modport slave (
    output w0_req, w0_data, w1_req, w1_data, rd_req,
           fifo_full, fifo_empty, fifo_dout,
    input  w0_gnt, w1_gnt, rd_gnt, rd_valid, rd_data,
           fifo_din, fifo_we_n, fifo_oe_n, busy
  );
endinterface

// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter
//   Round-robin access arbiter for one single-port SRAM FIFO shared by two
//   writers (W0, W1) and one reader (R). At most one FIFO operation every two
//   cycles; a write and a read are never issued together. Read data coming
//   out of the registered SRAM is re-registered toward the reader together
//   with a one-cycle valid strobe.
//
// Ports
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : fifo_access_arbiter_if.master
//          w0_req/w0_data/w0_gnt, w1_req/w1_data/w1_gnt  writer handshakes
//          rd_req/rd_gnt/rd_valid/rd_data                 reader handshake
//          fifo_din/fifo_we_n/fifo_oe_n                   FIFO control (active low)
//          fifo_full/fifo_empty/fifo_dout                 FIFO status and data
//          busy                                           high while in ACCESS
//
// State table
//   state  | meaning
//   IDLE   | enables high; arbitrate eligible requests, register the winner
//   ACCESS | exactly one enable low for one cycle; FIFO commits at its end
module fifo_access_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_access_arbiter_if.master bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_W0 = 2'd0,
    SRC_W1 = 2'd1,
    SRC_R  = 2'd2
  } src_e;

  state_e           state_q, state_d;
  src_e             rr_last_q, rr_last_d;
  logic             we_n_q, we_n_d;
  logic             oe_n_q, oe_n_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             w0_gnt_q, w0_gnt_d;
  logic             w1_gnt_q, w1_gnt_d;
  logic             rd_gnt_q, rd_gnt_d;
  logic             busy_q, busy_d;
  logic             rd_pending_q, rd_pending_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic elig_w0, elig_w1, elig_r;
  logic win_valid;
  src_e win_src;

  // Flags are sampled only in IDLE; since every ACCESS is followed by an
  // IDLE, the flags already reflect the previous operation when used here.
  always_comb begin
    elig_w0 = bus.w0_req & ~bus.fifo_full;
    elig_w1 = bus.w1_req & ~bus.fifo_full;
    elig_r  = bus.rd_req & ~bus.fifo_empty;
  end

  // Search order starts just after the last winner: W0 -> W1 -> R -> W0.
  always_comb begin
    win_src   = SRC_W0;
    win_valid = elig_w0 | elig_w1 | elig_r;
    case (rr_last_q)
      SRC_W0: begin
        if (elig_w1)      win_src = SRC_W1;
        else if (elig_r)  win_src = SRC_R;
        else              win_src = SRC_W0;
      end
      SRC_W1: begin
        if (elig_r)       win_src = SRC_R;
        else if (elig_w0) win_src = SRC_W0;
        else              win_src = SRC_W1;
      end
      default: begin
        if (elig_w0)      win_src = SRC_W0;
        else if (elig_w1) win_src = SRC_W1;
        else              win_src = SRC_R;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: every externally visible signal is registered, so the
  // values computed here appear in the cycle after the decision.
  always_comb begin
    we_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    din_d        = din_q;
    w0_gnt_d     = 1'b0;
    w1_gnt_d     = 1'b0;
    rd_gnt_d     = 1'b0;
    busy_d       = 1'b0;
    rr_last_d    = rr_last_q;
    rd_pending_d = rd_pending_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;

    // The registered SRAM presents the word in the cycle after its ACCESS,
    // which is always an IDLE cycle.
    if (rd_pending_q && (state_q == IDLE)) begin
      rd_data_d    = bus.fifo_dout;
      rd_valid_d   = 1'b1;
      rd_pending_d = 1'b0;
    end

    if ((state_q == IDLE) && win_valid) begin
      busy_d    = 1'b1;
      rr_last_d = win_src;
      case (win_src)
        SRC_W0: begin
          we_n_d   = 1'b0;
          din_d    = bus.w0_data;
          w0_gnt_d = 1'b1;
        end
        SRC_W1: begin
          we_n_d   = 1'b0;
          din_d    = bus.w1_data;
          w1_gnt_d = 1'b1;
        end
        default: begin
          oe_n_d       = 1'b0;
          rd_gnt_d     = 1'b1;
          rd_pending_d = 1'b1;
        end
      endcase
    end
  end

  // Output / datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q    <= SRC_R;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      din_q        <= '0;
      w0_gnt_q     <= 1'b0;
      w1_gnt_q     <= 1'b0;
      rd_gnt_q     <= 1'b0;
      busy_q       <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      rr_last_q    <= rr_last_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      din_q        <= din_d;
      w0_gnt_q     <= w0_gnt_d;
      w1_gnt_q     <= w1_gnt_d;
      rd_gnt_q     <= rd_gnt_d;
      busy_q       <= busy_d;
      rd_pending_q <= rd_pending_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign bus.fifo_we_n = we_n_q;
  assign bus.fifo_oe_n = oe_n_q;
  assign bus.fifo_din  = din_q;
  assign bus.w0_gnt    = w0_gnt_q;
  assign bus.w1_gnt    = w1_gnt_q;
  assign bus.rd_gnt    = rd_gnt_q;
  assign bus.busy      = busy_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
module tb_fifo_access_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_rst = 1'b1;

  always #5 clk = ~clk;

  fifo_access_arbiter_if #(.WIDTH(WIDTH)) bus ();

  fifo_access_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port FIFO with registered read; its own reset so
  // contents survive an arbiter reset.
  logic [WIDTH-1:0] mem [DEPTH];
  int               wp, rp, cnt;
  logic [WIDTH-1:0] dout;
  logic             push, pop;

  assign push           = (bus.fifo_we_n === 1'b0) && (cnt < DEPTH);
  assign pop            = (bus.fifo_oe_n === 1'b0) && (cnt > 0);
  assign bus.fifo_full  = (cnt == DEPTH);
  assign bus.fifo_empty = (cnt == 0);
  assign bus.fifo_dout  = dout;

  always @(posedge clk) begin
    if (fifo_rst) begin
      wp   <= 0;
      rp   <= 0;
      cnt  <= 0;
      dout <= '0;
    end else begin
      if (push) begin
        mem[wp] <= bus.fifo_din;
        wp      <= (wp + 1) % DEPTH;
      end
      if (pop) begin
        dout <= mem[rp];
        rp   <= (rp + 1) % DEPTH;
      end
      cnt <= cnt + (push ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  int               n_cmp = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cur_gnt();
    if (bus.w0_gnt === 1'b1) return 0;
    if (bus.w1_gnt === 1'b1) return 1;
    if (bus.rd_gnt === 1'b1) return 2;
    return -1;
  endfunction

  // Scoreboard and invariant monitor, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("we_oe_exclusive", {31'd0, bus.fifo_we_n | bus.fifo_oe_n}, 32'd1);
      if (bus.w0_gnt === 1'b1) begin
        check("w0_gnt_not_full", {31'd0, bus.fifo_full}, 32'd0);
        check("w0_gnt_we_n", {31'd0, bus.fifo_we_n}, 32'd0);
        check("w0_gnt_din", {24'd0, bus.fifo_din}, {24'd0, bus.w0_data});
        exp_q.push_back(bus.w0_data);
      end
      if (bus.w1_gnt === 1'b1) begin
        check("w1_gnt_not_full", {31'd0, bus.fifo_full}, 32'd0);
        check("w1_gnt_we_n", {31'd0, bus.fifo_we_n}, 32'd0);
        check("w1_gnt_din", {24'd0, bus.fifo_din}, {24'd0, bus.w1_data});
        exp_q.push_back(bus.w1_data);
      end
      if (bus.rd_gnt === 1'b1) begin
        check("rd_gnt_not_empty", {31'd0, bus.fifo_empty}, 32'd0);
        check("rd_gnt_oe_n", {31'd0, bus.fifo_oe_n}, 32'd0);
      end
      if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rd_valid_unexpected", {31'd0, bus.rd_valid}, 32'd0);
        end else begin
          check("rd_data_order", {24'd0, bus.rd_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(input int bound, output int id, output int n);
    id = -1;
    n  = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      n++;
      id = cur_gnt();
      if (id != -1) break;
    end
  endtask

  task automatic drain();
    bus.rd_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (exp_q.size() == 0 && cnt == 0) break;
    end
    bus.rd_req = 1'b0;
    check("drain_complete", exp_q.size(), 32'd0);
  endtask

  int rr_exp [10];
  int id, n, ops;
  logic seen;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.w0_req  = 1'b0;
    bus.w0_data = '0;
    bus.w1_req  = 1'b0;
    bus.w1_data = '0;
    bus.rd_req  = 1'b0;
    rr_exp = '{-1, 1, -1, 2, -1, 0, -1, 1, -1, 2};

    repeat (3) tick();
    fifo_rst = 1'b0;
    tick();
    check("rst_we_n", {31'd0, bus.fifo_we_n}, 32'd1);
    check("rst_oe_n", {31'd0, bus.fifo_oe_n}, 32'd1);
    check("rst_din", {24'd0, bus.fifo_din}, 32'd0);
    check("rst_gnts", {29'd0, bus.w0_gnt, bus.w1_gnt, bus.rd_gnt}, 32'd0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;

    // Reset in the middle of a write ACCESS
    bus.w0_req  = 1'b1;
    bus.w0_data = 8'h11;
    tick();
    check("t1_w0_gnt", {31'd0, bus.w0_gnt}, 32'd1);
    check("t1_we_n_low", {31'd0, bus.fifo_we_n}, 32'd0);
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    bus.w0_req = 1'b0;
    rst = 1'b1;
    tick();
    check("t1_rst_we_n", {31'd0, bus.fifo_we_n}, 32'd1);
    check("t1_rst_w0_gnt", {31'd0, bus.w0_gnt}, 32'd0);
    check("t1_rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    bus.w0_req  = 1'b1;
    bus.w0_data = 8'h33;
    bus.w1_req  = 1'b1;
    bus.w1_data = 8'h44;
    bus.rd_req  = 1'b1;
    tick();
    check("t1_first_gnt", cur_gnt(), 32'd0);
    bus.w0_data = bus.w0_data + 8'd1;

    // Round-robin with all three held
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_rr_order", cur_gnt(), rr_exp[i]);
      if (bus.w0_gnt === 1'b1) bus.w0_data = bus.w0_data + 8'd1;
      if (bus.w1_gnt === 1'b1) bus.w1_data = bus.w1_data + 8'd1;
    end
    bus.w0_req = 1'b0;
    bus.w1_req = 1'b0;
    drain();

    // Single write then read
    bus.w0_req  = 1'b1;
    bus.w0_data = 8'hA5;
    tick();
    check("t2_w0_gnt", {31'd0, bus.w0_gnt}, 32'd1);
    check("t2_we_n", {31'd0, bus.fifo_we_n}, 32'd0);
    check("t2_din", {24'd0, bus.fifo_din}, 32'h0000_00A5);
    bus.w0_req = 1'b0;
    tick();
    check("t2_no_double_gnt", {31'd0, bus.w0_gnt}, 32'd0);
    bus.rd_req = 1'b1;
    tick();
    check("t2_rd_gnt", {31'd0, bus.rd_gnt}, 32'd1);
    check("t2_oe_n", {31'd0, bus.fifo_oe_n}, 32'd0);
    bus.rd_req = 1'b0;
    tick();
    check("t2_rd_valid_early", {31'd0, bus.rd_valid}, 32'd0);
    tick();
    check("t2_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    check("t2_rd_data", {24'd0, bus.rd_data}, 32'h0000_00A5);
    tick();
    check("t2_rd_valid_pulse", {31'd0, bus.rd_valid}, 32'd0);
    check("t2_rd_data_hold", {24'd0, bus.rd_data}, 32'h0000_00A5);

    // Full blocking
    bus.w0_req  = 1'b1;
    bus.w0_data = 8'h50;
    for (int k = 0; k < DEPTH; k++) begin
      wait_gnt(6, id, n);
      check("t4_fill_gnt", id, 32'd0);
      bus.w0_data = bus.w0_data + 8'd1;
    end
    bus.w0_req  = 1'b0;
    bus.w1_req  = 1'b1;
    bus.w1_data = 8'h77;
    bus.rd_req  = 1'b1;
    wait_gnt(6, id, n);
    check("t4_full_rd_first", id, 32'd2);
    bus.rd_req = 1'b0;
    wait_gnt(6, id, n);
    check("t4_w1_after_full", id, 32'd1);
    check("t4_w1_latency", n, 32'd2);
    bus.w1_req = 1'b0;
    drain();

    // Empty blocking
    bus.rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_no_rd_gnt", {31'd0, bus.rd_gnt}, 32'd0);
      check("t5_oe_n_high", {31'd0, bus.fifo_oe_n}, 32'd1);
      check("t5_no_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    end
    bus.w0_req  = 1'b1;
    bus.w0_data = 8'h3C;
    wait_gnt(6, id, n);
    check("t5_w0_gnt", id, 32'd0);
    bus.w0_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.rd_gnt === 1'b1) bus.rd_req = 1'b0;
      if (bus.rd_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    bus.rd_req = 1'b0;
    check("t5_rd_valid_seen", {31'd0, seen}, 32'd1);
    check("t5_rd_data", {24'd0, bus.rd_data}, 32'h0000_003C);

    // Random ordering stress
    ops = 0;
    for (int c = 0; c < 6000 && ops < 300; c++) begin
      tick();
      if (cur_gnt() != -1) ops++;
      if (!bus.w0_req || bus.w0_gnt) begin
        bus.w0_req  = ($urandom_range(0, 2) == 0);
        bus.w0_data = WIDTH'($urandom);
      end
      if (!bus.w1_req || bus.w1_gnt) begin
        bus.w1_req  = ($urandom_range(0, 2) == 0);
        bus.w1_data = WIDTH'($urandom);
      end
      if (!bus.rd_req || bus.rd_gnt) begin
        bus.rd_req = ($urandom_range(0, 1) == 0);
      end
    end
    check("t6_ops_done", {31'd0, (ops >= 300)}, 32'd1);
    bus.w0_req = 1'b0;
    bus.w1_req = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    tick();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_access_arbiter.md
Name: fifo_access_arbiter

Overview:
- Round-robin arbiter sharing one single-port SRAM FIFO (WIDTH-bit, registered SRAM read) between two write requesters (W0, W1) and one read requester (R).
- Sequences the FIFO's active-low write/output enables: at most one FIFO operation per two cycles, never a write and a read together.
- Re-registers FIFO read data toward the reader with a valid strobe.
- Sits between client logic and the fifo instance; clients never drive the FIFO directly.

Parameters:
- WIDTH, 8, data width of clients and FIFO.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- w0_req  in  1  W0 write request; held with w0_data until w0_gnt.
- w0_data  in  WIDTH  W0 write data.
- w0_gnt  out  1  one-cycle pulse: W0 word is being written this cycle.
- w1_req  in  1  W1 write request; held with w1_data until w1_gnt.
- w1_data  in  WIDTH  W1 write data.
- w1_gnt  out  1  one-cycle pulse: W1 word is being written this cycle.
- rd_req  in  1  read request; held until rd_gnt.
- rd_gnt  out  1  one-cycle pulse: read access in progress this cycle.
- rd_valid  out  1  one-cycle pulse: rd_data holds the popped word.
- rd_data  out  WIDTH  popped word, stable until next rd_valid.
- fifo_din  out  WIDTH  to FIFO din.
- fifo_we_n  out  1  to FIFO we_n, active low.
- fifo_oe_n  out  1  to FIFO oe_n, active low.
- fifo_full  in  1  from FIFO full.
- fifo_empty  in  1  from FIFO empty.
- fifo_dout  in  WIDTH  from FIFO dout.
- busy  out  1  high while in ACCESS.

Behaviour:
- Reset (rst=1 at edge, any state, mid-access included):
  - state=IDLE; rr_last=R.
  - fifo_we_n=1, fifo_oe_n=1, fifo_din=0.
  - All gnt=0, rd_valid=0, rd_data=0, busy=0.
  - rd_pending cleared, so an interrupted read never produces rd_valid.
- Eligibility, evaluated in IDLE only:
  - W0 when w0_req & !fifo_full.
  - W1 when w1_req & !fifo_full.
  - R when rd_req & !fifo_empty.
  - Ineligible requests wait; they are never dropped or errored.
- Round-robin order, starting after rr_last: W0 -> W1 -> R -> W0. First eligible wins. rr_last updates to the winner. After reset, W0 has top priority.
- FSM states: IDLE, ACCESS.
  - IDLE with a winner: next state ACCESS. At the edge, register:
    - fifo_we_n=0 for a write winner, or fifo_oe_n=0 for a read winner (exactly one low).
    - fifo_din = winner data for a write; unchanged for a read.
    - The winner's gnt=1; busy=1.
  - IDLE with no winner: stay in IDLE, all enables high.
  - ACCESS: unconditional next state IDLE. Enables return to 1, gnts to 0, busy to 0. The FIFO commits the operation at the end of the ACCESS cycle.
  - FIFO flags are therefore already updated when IDLE next evaluates; no stale-flag overflow or underflow.
- Client handshake:
  - A client sees gnt high for exactly one cycle and may drop or change req/data from the next cycle on.
  - IDLE never follows IDLE-with-winner directly, so a still-high req in the gnt cycle is never granted twice.
- Read data path:
  - rd_pending is set on entering ACCESS for a read.
  - In the cycle after that ACCESS, fifo_dout is valid. At the end of that cycle rd_data<=fifo_dout, rd_valid<=1 for one cycle, rd_pending clears.
  - Latency from rd_req sampled in IDLE at cycle t: rd_gnt at t+1, rd_valid/rd_data at t+3.
- Throughput: one FIFO operation per 2 cycles maximum. Any mix of W0/W1/R is starvation-free; each eligible requester is served within 6 cycles.
- Simultaneous write and read requests are never merged; each takes its own ACCESS.
- fifo_din is held between operations, never glitching while enables are high.

Test Plan:
1. Reset mid-ACCESS: rst=1 during a write ACCESS -> next cycle fifo_we_n=1, w0_gnt=0, busy=0; first post-reset grant with W0, W1, R all eligible goes to W0.
2. Single write/read: W0 writes 0xA5 into an empty FIFO (w0_gnt one cycle, fifo_we_n=0 same cycle), then rd_req -> rd_gnt, and 2 cycles later rd_valid=1, rd_data=0xA5.
3. Round-robin: W0, W1, R held continuously, FIFO non-empty and non-full -> grant order W0, W1, R, W0, ... with one idle cycle between ACCESS cycles.
4. Full blocking: FIFO full, w1_req=1, rd_req=1 -> only R is granted; W1 is granted in the first IDLE after fifo_full drops.
5. Empty blocking: FIFO empty, rd_req=1 for 10 cycles -> no rd_gnt, fifo_oe_n stays 1, rd_valid stays 0; after a write of 0x3C, rd_valid later shows 0x3C.
6. Ordering stress: 300 random write/read requests with scoreboard -> popped sequence equals pushed sequence; no grant issued while the relevant flag blocks it; fifo_we_n and fifo_oe_n never low together.
